// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
// Pipeline register between instruction fetch and decode. It is a 2-entry skid
// buffer: a main entry that drives out_* and a skid entry that catches one
// extra instruction when decode stalls. in_ready comes from a register, so
// there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   flush          drop every held entry (mispredict / trap)
//   in_valid       fetch presents an instruction
//   in_ready       register can accept (registered)
//   in_pc          PC of the fetched instruction
//   in_instr       fetched instruction word
//   in_pred_taken  fetch-stage branch prediction bit
//   out_valid      decode-side head entry valid (registered)
//   out_ready      decode consumes the head entry
//   out_pc         PC of the head entry
//   out_instr      head instruction; NOP_INSTR when out_valid=0
//   out_pred_taken head prediction bit; 0 when out_valid=0
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_pred_taken
);

    localparam int unsigned ILEN = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    // Main entry doubles as the output register.
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [ILEN-1:0] main_instr_q, main_instr_d;
    logic            main_pred_q, main_pred_d;

    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [ILEN-1:0] skid_instr_q, skid_instr_d;
    logic            skid_pred_q, skid_pred_d;

    logic            accept;
    logic            consume;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    // Next-state, entry movement and registered-output precompute.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        main_pred_d  = main_pred_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pred_d  = skid_pred_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_FULL;
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                    main_pred_d  = in_pred_taken;
                end
            end
            ST_FULL: begin
                if (accept && consume) begin
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                    main_pred_d  = in_pred_taken;
                end else if (accept) begin
                    state_d      = ST_SKID;
                    skid_pc_d    = in_pc;
                    skid_instr_d = in_instr;
                    skid_pred_d  = in_pred_taken;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only a consume can move things.
                if (consume) begin
                    state_d      = ST_FULL;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                    main_pred_d  = skid_pred_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush wins over any accept in the same cycle.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Empty register presents a harmless NOP to decode.
        if (state_d == ST_EMPTY) begin
            main_instr_d = NOP_INSTR;
            main_pred_d  = 1'b0;
        end

        in_ready_d  = (state_d != ST_SKID);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Control state and the visible head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_pc_q    <= XLEN'(0);
            main_instr_q <= NOP_INSTR;
            main_pred_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            main_pred_q  <= main_pred_d;
        end
    end

    // Skid payload is only ever read when its state says it is valid.
    always_ff @(posedge clk) begin
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pred_q  <= skid_pred_d;
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = main_pc_q;
    assign out_instr      = main_instr_q;
    assign out_pred_taken = main_pred_q;

endmodule
